// File: rtl/imm_ext_stage.sv
// imm_ext_stage
//   Decodes the immediate field of a RISC-V instruction at the moment a
//   request is accepted. The result travels with its sideband tag through a
//   two-entry elastic buffer: the output register (main) plus one skid entry.
//   in_ready depends only on registered state and reset, never on out_ready.
//
// Ports
//   clock, reset        sole clock; synchronous active-high reset
//   in_valid/in_ready   request handshake
//   in_inst [24:0]      instruction bits [31:7]
//   in_op   [2:0]       immediate format select (111 = illegal)
//   in_tag              sideband, passed through unmodified
//   out_valid/out_ready result handshake
//   out_imm             generated immediate, DATA_WIDTH bits
//   out_tag             tag of the presented result
//   out_err             presented result came from an illegal op
//   ext_count [31:0]    completed output transfers, saturating
module imm_ext_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [24:0]           in_inst,
    input  logic [2:0]            in_op,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  out_err,
    output logic [31:0]           ext_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_in_xfer;
    logic                  w_out_xfer;
    logic                  w_ld_main_in;
    logic                  w_ld_main_skid;
    logic                  w_ld_skid;
    logic [DATA_WIDTH-1:0] w_imm;
    logic                  w_err;

    logic [DATA_WIDTH-1:0] r_main_imm;
    logic [TAG_WIDTH-1:0]  r_main_tag;
    logic                  r_main_err;
    logic [DATA_WIDTH-1:0] r_skid_imm;
    logic [TAG_WIDTH-1:0]  r_skid_tag;
    logic                  r_skid_err;
    logic [31:0]           r_ext_count;

    // The argument is indexed [31:7] so bit numbers match the instruction word.
    function automatic logic [DATA_WIDTH-1:0] f_imm(input logic [31:7] i,
                                                     input logic [2:0]  op);
        logic signed [31:0]           v32;
        logic signed [DATA_WIDTH-1:0] ext;
        logic [DATA_WIDTH-1:0]        res;
        v32 = '0;
        case (op)
            3'b000:  v32 = {{20{i[31]}}, i[31:20]};
            3'b001:  v32 = {i[31:12], 12'b0};
            3'b010:  v32 = {{20{i[31]}}, i[31:25], i[11:7]};
            3'b011:  v32 = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'b100:  v32 = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: v32 = '0;
        endcase
        // Size cast of a signed value sign-extends for the 64-bit build.
        ext = DATA_WIDTH'(v32);
        res = ext;
        case (op)
            3'b101: begin
                res      = '0;
                res[4:0] = i[19:15];
            end
            3'b110: begin
                res = '0;
                if (DATA_WIDTH == 64) res[5:0] = i[25:20];
                else                  res[4:0] = i[24:20];
            end
            3'b111:  res = '0;
            default: res = ext;
        endcase
        return res;
    endfunction

    assign w_imm = f_imm(in_inst, in_op);
    assign w_err = (in_op == 3'b111);

    // Handshakes are decoded from state only; reset masks both sides.
    assign in_ready   = !reset && (r_state != ST_TWO);
    assign out_valid  = !reset && (r_state != ST_EMPTY);
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_EMPTY;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_xfer) begin
                    w_ld_main_in = 1'b1;
                    w_state_nxt  = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_ld_main_in = 1'b1;
                end else if (w_in_xfer) begin
                    w_ld_skid   = 1'b1;
                    w_state_nxt = ST_TWO;
                end else if (w_out_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_out_xfer) begin
                    w_ld_main_skid = 1'b1;
                    w_state_nxt    = ST_ONE;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_main_imm <= '0;
            r_main_tag <= '0;
            r_main_err <= 1'b0;
        end else if (w_ld_main_in) begin
            r_main_imm <= w_imm;
            r_main_tag <= in_tag;
            r_main_err <= w_err;
        end else if (w_ld_main_skid) begin
            r_main_imm <= r_skid_imm;
            r_main_tag <= r_skid_tag;
            r_main_err <= r_skid_err;
        end
    end

    // Skid contents are only meaningful in ST_TWO, so they need no reset.
    always_ff @(posedge clock) begin
        if (w_ld_skid) begin
            r_skid_imm <= w_imm;
            r_skid_tag <= in_tag;
            r_skid_err <= w_err;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)                                  r_ext_count <= '0;
        else if (w_out_xfer && (r_ext_count != '1)) r_ext_count <= r_ext_count + 32'd1;
    end

    assign out_imm   = r_main_imm;
    assign out_tag   = r_main_tag;
    assign out_err   = r_main_err;
    assign ext_count = r_ext_count;

endmodule

// File: tb/tb_imm_ext_stage.sv
module tb_imm_ext_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [24:0] in_inst;
    logic [2:0]  in_op;
    logic [31:0] in_tag;

    logic        rdy32, vld32, err32;
    logic [31:0] imm32, tag32, cnt32;
    logic        rdy64, vld64, err64;
    logic [63:0] imm64;
    logic [31:0] tag64, cnt64;

    always #5 clock = ~clock;

    imm_ext_stage #(.DATA_WIDTH(32), .TAG_WIDTH(32)) dut32 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
        .in_inst(in_inst), .in_op(in_op), .in_tag(in_tag),
        .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32),
        .out_tag(tag32), .out_err(err32), .ext_count(cnt32)
    );

    imm_ext_stage #(.DATA_WIDTH(64), .TAG_WIDTH(32)) dut64 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy64),
        .in_inst(in_inst), .in_op(in_op), .in_tag(in_tag),
        .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64),
        .out_tag(tag64), .out_err(err64), .ext_count(cnt64)
    );

    typedef struct {
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [31:0] tag;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_chk   = 0;
    int   n_fail  = 0;
    int   exp_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: immediate as a plain integer assembled from weighted fields.
    function automatic logic [63:0] ref_imm(input logic [24:0] inst, input logic [2:0] op,
                                            input int dw);
        logic [31:0] w;
        longint      sw;
        longint      v;
        w  = {inst, 7'b0};
        sw = longint'($signed(w));
        case (op)
            3'd0: v = sw >>> 20;
            3'd1: v = (sw >>> 12) * 4096;
            3'd2: v = (sw >>> 25) * 32 + longint'(w[11:7]);
            3'd3: v = (w[31] ? -64'sd4096 : 64'sd0) + longint'(w[7]) * 2048
                      + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
            3'd4: v = (w[31] ? -64'sd1048576 : 64'sd0) + longint'(w[19:12]) * 4096
                      + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
            3'd5: v = longint'(w[19:15]);
            3'd6: v = (dw == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
            default: v = 0;
        endcase
        return v;
    endfunction

    // One clock: record an acceptance at the negedge, return 1 ns past the posedge.
    task automatic step(output bit acc);
        exp_t        e;
        logic [63:0] r32;
        @(negedge clock);
        acc = in_valid && rdy32;
        if (acc) begin
            r32     = ref_imm(in_inst, in_op, 32);
            e.imm32 = r32[31:0];
            e.imm64 = ref_imm(in_inst, in_op, 64);
            e.tag   = in_tag;
            e.err   = (in_op == 3'd7);
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [31:0] word, input logic [2:0] op, input logic [31:0] tag);
        in_valid = 1'b1;
        in_inst  = word[31:7];
        in_op    = op;
        in_tag   = tag;
    endtask

    // Monitor: compares every output transfer against the scoreboard.
    logic        have_hold;
    logic [31:0] h_imm32, h_tag;
    logic [63:0] h_imm64;
    logic        h_err;
    exp_t        m_e;

    always @(negedge clock) begin
        if (reset) begin
            sb.delete();
            exp_cnt   = 0;
            have_hold = 1'b0;
        end else begin
            chk("ext_count32", cnt32, exp_cnt);
            chk("ext_count64", cnt64, exp_cnt);
            chk("valid_32_vs_64", vld64, vld32);
            chk("ready_32_vs_64", rdy64, rdy32);
            if (have_hold) begin
                chk("hold_valid", vld32, 1);
                chk("hold_imm32", imm32, h_imm32);
                chk("hold_imm64", imm64, h_imm64);
                chk("hold_tag", tag32, h_tag);
                chk("hold_err", err32, h_err);
            end
            if (vld32 && out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: tag 0x%0h appeared, expected none", tag32);
                end else begin
                    m_e = sb.pop_front();
                    chk("out_imm32", imm32, m_e.imm32);
                    chk("out_imm64", imm64, m_e.imm64);
                    chk("out_tag32", tag32, m_e.tag);
                    chk("out_tag64", tag64, m_e.tag);
                    chk("out_err32", err32, m_e.err);
                    chk("out_err64", err64, m_e.err);
                end
                exp_cnt++;
            end
            have_hold = vld32 && !out_ready;
            h_imm32   = imm32;
            h_imm64   = imm64;
            h_tag     = tag32;
            h_err     = err32;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_inst   = '0;
        in_op     = '0;
        in_tag    = '0;
        #1;
        chk("in_ready_during_reset", rdy32, 0);
        repeat (2) step(acc);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", vld32, 0);
        chk("rst_in_ready", rdy32, 1);
        chk("rst_out_imm", imm32, 0);
        chk("rst_out_tag", tag32, 0);
        chk("rst_out_err", err32, 0);
        chk("rst_ext_count", cnt32, 0);

        // I-type, one-cycle latency
        out_ready = 1'b1;
        offer(32'hFFF00093, 3'd0, 32'h11);
        step(acc);
        chk("itype_accept", acc, 1);
        in_valid = 1'b0;
        #1;
        chk("itype_valid", vld32, 1);
        chk("itype_imm", imm32, 32'hFFFFFFFF);
        chk("itype_err", err32, 0);
        step(acc);
        chk("itype_count", cnt32, 1);

        // B-type
        offer(32'hFE000EE3, 3'd3, 32'h22);
        step(acc);
        in_valid = 1'b0;
        #1;
        chk("btype_imm32", imm32, 32'hFFFFFFFC);
        chk("btype_imm64", imm64, 64'hFFFFFFFFFFFFFFFC);
        step(acc);

        // Illegal op
        offer($urandom, 3'd7, 32'h33);
        step(acc);
        in_valid = 1'b0;
        #1;
        chk("illegal_imm", imm32, 0);
        chk("illegal_err", err32, 1);
        step(acc);
        chk("illegal_count", cnt32, 3);

        // 64-bit U-type and shamt
        offer(32'h800000B7, 3'd1, 32'h44);
        step(acc);
        in_valid = 1'b0;
        #1;
        chk("utype_imm64", imm64, 64'hFFFFFFFF80000000);
        offer(32'h03F00000, 3'd6, 32'h55);
        step(acc);
        in_valid = 1'b0;
        #1;
        chk("shamt_imm64", imm64, 64'd63);
        chk("shamt_imm32", imm32, 32'd31);
        step(acc);

        // Backpressure: A and B accepted, C held until space frees
        out_ready = 1'b0;
        offer($urandom, 3'd0, 32'hA);
        step(acc);
        offer($urandom, 3'd2, 32'hB);
        step(acc);
        offer($urandom, 3'd4, 32'hC);
        #1;
        chk("c_blocked_ready", rdy32, 0);
        step(acc);
        chk("c_not_accepted", acc, 0);
        chk("a_presented", tag32, 32'hA);
        out_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 10 && !acc; k++) step(acc);
        chk("c_accepted", acc, 1);
        in_valid = 1'b0;
        repeat (4) step(acc);

        // Reset while full discards both held items
        out_ready = 1'b0;
        offer($urandom, 3'd0, 32'hD0);
        step(acc);
        offer($urandom, 3'd1, 32'hD1);
        step(acc);
        in_valid = 1'b0;
        #1;
        chk("full_in_ready", rdy32, 0);
        reset = 1'b1;
        #1;
        chk("mid_rst_in_ready", rdy32, 0);
        chk("mid_rst_out_valid", vld32, 0);
        step(acc);
        reset = 1'b0;
        #1;
        chk("post_rst_out_valid", vld32, 0);
        chk("post_rst_count", cnt32, 0);
        chk("post_rst_in_ready", rdy32, 1);
        out_ready = 1'b1;
        repeat (3) step(acc);

        // Randomized traffic
        repeat (3000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_inst   = 25'($urandom);
            in_op     = 3'($urandom_range(0, 7));
            in_tag    = $urandom;
            out_ready = ($urandom_range(0, 9) < 6);
            step(acc);
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10 && sb.size() != 0; k++) step(acc);
        step(acc);
        chk("drain_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_ext_stage.md
IMM_EXT_STAGE -- requirements
Module: ysyx_25030081_imm_ext_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, immediate width; legal values 32 and 64 only.
REQ-002 SHALL have parameter TAG_WIDTH, default 32, width of the sideband tag (e.g. PC) carried with each request.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  request valid.
REQ-006 SHALL have port in_ready  output  1  stage can accept a request.
REQ-007 SHALL have port in_inst  input  25  instruction bits [31:7].
REQ-008 SHALL have port in_op  input  3  immediate format select.
REQ-009 SHALL have port in_tag  input  TAG_WIDTH  sideband, passed through unmodified.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port out_imm  output  DATA_WIDTH  generated immediate.
REQ-013 SHALL have port out_tag  output  TAG_WIDTH  tag of the result.
REQ-014 SHALL have port out_err  output  1  in_op was illegal for this request.
REQ-015 SHALL have port ext_count  output  32  number of completed output transfers.

Function
REQ-016 SHALL decode in_op (i = instruction bit index, s = sign-extend to DATA_WIDTH from i[31]): 000 I = s(i[31:20]); 001 U = s({i[31:12],12'b0}); 010 S = s({i[31:25],i[11:7]}); 011 B = s({i[31],i[7],i[30:25],i[11:8],0}); 100 J = s({i[31],i[19:12],i[20],i[30:21],0}).
REQ-017 SHALL decode 101 CSR-zimm = zero-extended i[19:15]; 110 shamt = zero-extended i[25:20] when DATA_WIDTH=64, i[24:20] when 32.
REQ-018 SHALL decode 111 as illegal: out_imm = 0 and out_err = 1 for that request; out_err = 0 for every other op.
REQ-019 SHALL define in-transfer as in_valid && in_ready and out-transfer as out_valid && out_ready, both sampled at the clock edge.
REQ-020 SHALL hold at most two requests: output register (main) plus one skid entry; FSM states EMPTY, ONE, TWO.
REQ-021 SHALL drive in_ready = 1 in EMPTY and ONE and 0 in TWO, decoded from registered state only (no combinational path from out_ready).
REQ-022 SHALL drive out_valid = 1 in ONE and TWO and 0 in EMPTY.
REQ-023 SHALL transition EMPTY: on in-transfer, load main, go to ONE; otherwise stay.
REQ-024 SHALL transition ONE: in-transfer with out-transfer reloads main and stays ONE; in-transfer alone loads skid and goes to TWO; out-transfer alone goes to EMPTY; neither stays ONE.
REQ-025 SHALL transition TWO: on out-transfer move skid into main and go to ONE; otherwise stay.
REQ-026 SHALL give latency exactly one cycle from in-transfer to out_valid when the stage is empty, and sustain one transfer per cycle while out_ready is held high.
REQ-027 SHALL keep out_imm, out_tag and out_err stable while out_valid = 1 and out_ready = 0.
REQ-028 SHALL deliver results in strict acceptance order, with no drops and no duplicates.
REQ-029 SHALL compute each immediate at acceptance and store it; stored results SHALL NOT depend on later in_inst or in_op values.
REQ-030 SHALL increment ext_count by 1 on each out-transfer, saturating at 0xFFFFFFFF.
REQ-031 SHALL ignore in_inst, in_op and in_tag whenever in_valid = 0 or in_ready = 0.

Reset
REQ-032 SHALL, in any cycle with reset = 1, enter EMPTY and clear out_imm, out_tag, out_err and ext_count to 0; out_valid = 0.
REQ-033 SHALL force in_ready = 0 while reset = 1 and accept no request in that cycle.
REQ-034 SHALL discard any requests held at reset, including a reset asserted mid-operation in state TWO, and produce no output transfer for them.

Verification
REQ-035 SHALL pass: I-type, word 0xFFF00093, op 000, out_ready = 1 -> next cycle out_valid = 1, out_imm = 0xFFFFFFFF, out_err = 0, ext_count = 1.
REQ-036 SHALL pass: B-type, word 0xFE000EE3, op 011 -> out_imm = 0xFFFFFFFC.
REQ-037 SHALL pass: out_ready = 0, offer tags A, B, C on consecutive cycles -> A and B accepted, in_ready = 0 while C is held; raise out_ready -> A, then B, then C delivered in order.
REQ-038 SHALL pass: op 111 with any word -> out_imm = 0, out_err = 1, ext_count increments.
REQ-039 SHALL pass: DATA_WIDTH = 64, word 0x800000B7, op 001 -> out_imm = 0xFFFFFFFF80000000; op 110 with i[25:20] = 0x3F -> out_imm = 63.
REQ-040 SHALL pass: fill to TWO, assert reset for one cycle -> out_valid = 0, ext_count = 0, in_ready = 1 the cycle after reset deasserts, held items never appear.
